// File: rtl/x3q16_memctl_if.sv
// CPU-side request/response bus of the x3q16 memory controller.
// The master drives requests; the slave (memory controller) returns data and status pulses.
interface x3q16_memctl_if;
  logic        request;
  logic        request_type;
  logic [15:0] request_address;
  logic [15:0] data_in;
  logic [15:0] memory_out;
  logic        memory_ready;
  logic        write_complete;
  logic        memory_critical;
  logic        busy;

  modport master (
    output request, request_type, request_address, data_in,
    input  memory_out, memory_ready, write_complete, memory_critical, busy
  );

  modport slave (
    input  request, request_type, request_address, data_in,
    output memory_out, memory_ready, write_complete, memory_critical, busy
  );
endinterface

// File: rtl/x3q16_memctl.sv
// Single-port 16-bit word memory with a fixed-latency request/response FSM and a
// side loader port for program preload while the controller is idle.
module x3q16_memctl #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  x3q16_memctl_if.slave        bus,
  input  logic                 load_en,
  input  logic [15:0]          load_addr,
  input  logic [15:0]          load_data
);

  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_LD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  logic [DATA_W-1:0]    mem [DEPTH];

  state_t               state;
  logic [3:0]           cnt;

  logic                 req_type_p0;
  logic [15:0]          req_addr_p0;
  logic [DATA_W-1:0]    req_data_p0;

  logic [DATA_W-1:0]    mem_out_p1;
  logic                 rdy_p1;
  logic                 wc_p1;
  logic                 crit_p1;
  logic                 busy_p1;

  logic                 accept;
  logic                 req_in_range;
  logic                 load_in_range;
  logic                 commit_wr;
  logic                 load_ok;
  logic [ADDR_BITS-1:0] req_idx;
  logic [ADDR_BITS-1:0] load_idx;

  assign accept        = bus.request && (state != WAIT);
  assign req_in_range  = (req_addr_p0 >> ADDR_BITS) == 16'd0;
  assign load_in_range = (load_addr >> ADDR_BITS) == 16'd0;
  assign req_idx       = req_addr_p0[ADDR_BITS-1:0];
  assign load_idx      = load_addr[ADDR_BITS-1:0];
  assign commit_wr     = (state == RESP) && req_type_p0 && req_in_range;
  assign load_ok       = load_en && (state == IDLE) && !bus.request && load_in_range;

  // Stage p0: capture the accepted request; data path carries no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      req_type_p0 <= bus.request_type;
      req_addr_p0 <= bus.request_address;
      req_data_p0 <= bus.data_in;
    end
  end

  // Array: response writes and loader writes can never coincide (RESP vs IDLE)
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      mem[req_idx] <= req_data_p0;
    end else if (load_ok) begin
      mem[load_idx] <= load_data;
    end
  end

  // Stage p1: FSM and registered response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      mem_out_p1 <= '0;
      rdy_p1     <= 1'b0;
      wc_p1      <= 1'b0;
      crit_p1    <= 1'b0;
      busy_p1    <= 1'b0;
    end else begin
      rdy_p1  <= 1'b0;
      wc_p1   <= 1'b0;
      crit_p1 <= 1'b0;
      if (state == RESP) begin
        crit_p1 <= !req_in_range;
        if (req_type_p0) begin
          wc_p1 <= 1'b1;
        end else begin
          rdy_p1     <= 1'b1;
          mem_out_p1 <= req_in_range ? mem[req_idx] : '0;
        end
      end
      case (state)
        IDLE, RESP: begin
          if (bus.request) begin
            state   <= (WAIT_STATES > 0) ? WAIT : RESP;
            cnt     <= WAIT_LD;
            busy_p1 <= 1'b1;
          end else begin
            state   <= IDLE;
            busy_p1 <= 1'b0;
          end
        end
        WAIT: begin
          busy_p1 <= 1'b1;
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state   <= IDLE;
          busy_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign bus.memory_out      = mem_out_p1;
  assign bus.memory_ready    = rdy_p1;
  assign bus.write_complete  = wc_p1;
  assign bus.memory_critical = crit_p1;
  assign bus.busy            = busy_p1;

endmodule

// File: tb/tb_x3q16_memctl.sv
// Scoreboard bench for x3q16_memctl: one instance with two wait states, one with none.
module tb_x3q16_memctl;

  typedef struct {
    bit          wr;
    bit          crit;
    logic [15:0] data;
    int          due;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        ld_en0, ld_en1;
  logic [15:0] ld_addr0, ld_addr1, ld_data0, ld_data1;

  x3q16_memctl_if bus0 ();
  x3q16_memctl_if bus1 ();

  x3q16_memctl #(.ADDR_BITS(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0),
    .load_en(ld_en0), .load_addr(ld_addr0), .load_data(ld_data0)
  );

  x3q16_memctl #(.ADDR_BITS(8), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus1),
    .load_en(ld_en1), .load_addr(ld_addr1), .load_data(ld_data1)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  sb_t         q0[$];
  sb_t         q1[$];
  logic [15:0] mdl [2][256];
  logic [15:0] exp_out [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input int k, input logic req, input logic typ,
                       input logic [15:0] a, input logic [15:0] d);
    if (k == 0) begin
      bus0.request = req; bus0.request_type = typ; bus0.request_address = a; bus0.data_in = d;
    end else begin
      bus1.request = req; bus1.request_type = typ; bus1.request_address = a; bus1.data_in = d;
    end
  endtask

  // Drives one request at the current negedge; optionally records its expected response.
  task automatic issue(input int k, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input bit expect_resp);
    sb_t e;
    int  w;
    w = (k == 1) ? 2 : 0;
    drive(k, 1'b1, wr, a, d);
    if (expect_resp) begin
      e.wr   = wr;
      e.crit = (a >= 16'd256);
      e.data = (!wr && a < 16'd256) ? mdl[k][a[7:0]] : 16'h0000;
      e.due  = cyc + w + 2;
      if (k == 0) q0.push_back(e); else q1.push_back(e);
      if (wr && a < 16'd256) mdl[k][a[7:0]] = d;
    end
    @(negedge clk);
    drive(k, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic load(input int k, input logic [15:0] a, input logic [15:0] d, input bit upd);
    if (k == 0) begin ld_en0 = 1'b1; ld_addr0 = a; ld_data0 = d; end
    else        begin ld_en1 = 1'b1; ld_addr1 = a; ld_data1 = d; end
    if (upd && a < 16'd256) mdl[k][a[7:0]] = d;
    @(negedge clk);
    ld_en0 = 1'b0;
    ld_en1 = 1'b0;
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (((k == 0) ? q0.size() : q1.size()) != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk("timeout", 32'(n), 32'd0);
      if (k == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic mon(input int k, input logic rdy, input logic wc, input logic crit,
                     input logic [15:0] mout, input logic rn);
    sb_t e;
    int  sz;
    sz = (k == 0) ? q0.size() : q1.size();
    if (!rn) exp_out[k] = 16'h0000;
    if (rdy || wc) begin
      if (sz == 0) begin
        chk($sformatf("unexpected_resp%0d", k), {30'd0, rdy, wc}, 32'd0);
      end else begin
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("both_pulses%0d", k), 32'(rdy & wc), 32'd0);
        chk($sformatf("resp_type%0d", k), 32'(wc), 32'(e.wr));
        chk($sformatf("crit%0d", k), 32'(crit), 32'(e.crit));
        chk($sformatf("latency%0d", k), 32'(cyc), 32'(e.due));
        if (!e.wr) exp_out[k] = e.data;
      end
    end else begin
      if (crit) chk($sformatf("stray_crit%0d", k), 32'(crit), 32'd0);
      if (sz > 0) begin
        e = (k == 0) ? q0[0] : q1[0];
        if (e.due < cyc) begin
          chk($sformatf("late_resp%0d", k), 32'(cyc), 32'(e.due));
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
    chk($sformatf("memory_out%0d", k), 32'(mout), 32'(exp_out[k]));
  endtask

  always @(negedge clk) begin
    mon(0, bus0.memory_ready, bus0.write_complete, bus0.memory_critical, bus0.memory_out, reset_n);
    mon(1, bus1.memory_ready, bus1.write_complete, bus1.memory_critical, bus1.memory_out, reset_n);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_out[0] = 16'h0000;
    exp_out[1] = 16'h0000;
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    ld_en0 = 1'b0; ld_addr0 = 16'h0000; ld_data0 = 16'h0000;
    ld_en1 = 1'b0; ld_addr1 = 16'h0000; ld_data1 = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_mout", 32'(bus1.memory_out), 32'd0);
    chk("rst_ready", 32'(bus1.memory_ready), 32'd0);
    chk("rst_wc", 32'(bus1.write_complete), 32'd0);
    chk("rst_crit", 32'(bus1.memory_critical), 32'd0);
    chk("rst_busy", 32'(bus1.busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Preload, then read with two wait states
    load(1, 16'h0000, 16'h1234, 1'b1);
    load(1, 16'h0020, 16'h5555, 1'b1);
    load(1, 16'h0030, 16'h3333, 1'b1);
    load(1, 16'h0005, 16'h0505, 1'b1);
    load(1, 16'h0105, 16'hDEAD, 1'b1);
    issue(1, 1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("busy_in_wait", 32'(bus1.busy), 32'd1);
    wait_done(1);
    @(negedge clk);
    chk("busy_after", 32'(bus1.busy), 32'd0);
    chk("preload_read", 32'(bus1.memory_out), 32'h1234);

    // Write then read back
    issue(1, 1'b1, 16'h0010, 16'hBEEF, 1'b1);
    wait_done(1);
    issue(1, 1'b0, 16'h0010, 16'h0000, 1'b1);
    wait_done(1);

    // Out-of-range write and read, then confirm word 0 and the dropped load
    issue(1, 1'b1, 16'h0100, 16'hAAAA, 1'b1);
    wait_done(1);
    issue(1, 1'b0, 16'h0100, 16'h0000, 1'b1);
    wait_done(1);
    issue(1, 1'b0, 16'h0000, 16'h0000, 1'b1);
    wait_done(1);
    issue(1, 1'b0, 16'h0005, 16'h0000, 1'b1);
    wait_done(1);

    // Request and load arriving during WAIT are ignored
    issue(1, 1'b0, 16'h0020, 16'h0000, 1'b1);
    issue(1, 1'b1, 16'h0031, 16'h9999, 1'b0);
    load(1, 16'h0030, 16'h7777, 1'b0);
    wait_done(1);
    repeat (3) @(negedge clk);
    issue(1, 1'b0, 16'h0030, 16'h0000, 1'b1);
    wait_done(1);

    // Reset during WAIT aborts a write; first edge after release is served
    issue(1, 1'b1, 16'h0020, 16'h1111, 1'b0);
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("abort_mout", 32'(bus1.memory_out), 32'd0);
    chk("abort_ready", 32'(bus1.memory_ready), 32'd0);
    chk("abort_wc", 32'(bus1.write_complete), 32'd0);
    chk("abort_crit", 32'(bus1.memory_critical), 32'd0);
    chk("abort_busy", 32'(bus1.busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(1, 1'b0, 16'h0020, 16'h0000, 1'b1);
    wait_done(1);

    // Zero wait states: back-to-back requests, one per RESP cycle
    load(0, 16'h0001, 16'h1111, 1'b1);
    load(0, 16'h0002, 16'h2222, 1'b1);
    load(0, 16'h0003, 16'h3333, 1'b1);
    load(0, 16'h00FF, 16'hF0F0, 1'b1);
    issue(0, 1'b0, 16'h0001, 16'h0000, 1'b1);
    issue(0, 1'b0, 16'h0002, 16'h0000, 1'b1);
    issue(0, 1'b0, 16'h0003, 16'h0000, 1'b1);
    issue(0, 1'b0, 16'h00FF, 16'h0000, 1'b1);
    issue(0, 1'b0, 16'h0200, 16'h0000, 1'b1);
    issue(0, 1'b1, 16'h0008, 16'hCAFE, 1'b1);
    issue(0, 1'b0, 16'h0008, 16'h0000, 1'b1);
    issue(0, 1'b0, 16'h0002, 16'h0000, 1'b1);
    wait_done(0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
